// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Bus bundle for the work/video RAM arbiter (CPU, video, RAM sides).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int XLEN       = 8,
    parameter int ADDR_WIDTH = 13
);
    logic [2*XLEN-1:0]     cpu_addr;
    logic                  cpu_sel;
    logic                  cpu_dbin;
    logic                  cpu_write_n;
    logic [XLEN-1:0]       cpu_wdata;
    logic [XLEN-1:0]       cpu_rdata;
    logic                  cpu_ready;
    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_ack;
    logic [XLEN-1:0]       vid_rdata;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [XLEN-1:0]       ram_wdata;
    logic [XLEN-1:0]       ram_rdata;

    // Arbiter side
    modport slave (
        input  cpu_addr, cpu_sel, cpu_dbin, cpu_write_n, cpu_wdata,
        input  vid_req, vid_addr, ram_rdata,
        output cpu_rdata, cpu_ready, vid_ack, vid_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    // Requesters and RAM side
    modport master (
        output cpu_addr, cpu_sel, cpu_dbin, cpu_write_n, cpu_wdata,
        output vid_req, vid_addr, ram_rdata,
        input  cpu_rdata, cpu_ready, vid_ack, vid_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares a single-port sync RAM between the i8080 core and video
//           scan-out; video has priority, limited by a streak counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int XLEN           = 8,
    parameter int ADDR_WIDTH     = 13,
    parameter int VID_MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus_if
);

    localparam int SW = $clog2(VID_MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(VID_MAX_STREAK);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU_ACC  = 3'd1,
        S_CPU_WAIT = 3'd2,
        S_CPU_HOLD = 3'd3,
        S_VID_ACC  = 3'd4,
        S_VID_WAIT = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [XLEN-1:0]       ram_wdata_q, ram_wdata_d;
    logic [XLEN-1:0]       cpu_rdata_q, cpu_rdata_d;

    logic w_cpu_rd;
    logic w_cpu_wr;
    logic w_cpu_pend;
    logic w_vid_grant;
    logic w_unused_addr_hi;

    // A simultaneous read+write strobe is treated as a write.
    assign w_cpu_wr   = bus_if.cpu_sel & ~bus_if.cpu_write_n;
    assign w_cpu_rd   = bus_if.cpu_sel & bus_if.cpu_dbin;
    assign w_cpu_pend = w_cpu_rd | w_cpu_wr;

    assign w_vid_grant = bus_if.vid_req & ~(w_cpu_pend & (streak_q == STREAK_MAX));

    // CPU address is truncated to the RAM word address.
    assign w_unused_addr_hi = ^bus_if.cpu_addr[2*XLEN-1:ADDR_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            is_wr_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            is_wr_q     <= is_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        is_wr_d     = is_wr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_rdata_d = cpu_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_vid_grant) begin
                    state_d    = S_VID_ACC;
                    ram_addr_d = bus_if.vid_addr;
                    if (!w_cpu_pend) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (w_cpu_pend) begin
                    state_d    = S_CPU_ACC;
                    streak_d   = '0;
                    is_wr_d    = w_cpu_wr;
                    ram_addr_d = bus_if.cpu_addr[ADDR_WIDTH-1:0];
                    if (w_cpu_wr) begin
                        ram_wdata_d = bus_if.cpu_wdata;
                    end
                end
            end
            S_CPU_ACC:  state_d = is_wr_q ? S_CPU_HOLD : S_CPU_WAIT;
            S_CPU_WAIT: begin
                state_d     = S_CPU_HOLD;
                cpu_rdata_d = bus_if.ram_rdata;
            end
            // Hold the CPU in its completed cycle until both strobes drop.
            S_CPU_HOLD: begin
                if (!w_cpu_pend) begin
                    state_d = S_IDLE;
                end
            end
            S_VID_ACC:  state_d = S_VID_WAIT;
            S_VID_WAIT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    assign bus_if.ram_en    = (state_q == S_CPU_ACC) | (state_q == S_VID_ACC);
    assign bus_if.ram_we    = (state_q == S_CPU_ACC) & is_wr_q;
    assign bus_if.ram_addr  = ram_addr_q;
    assign bus_if.ram_wdata = ram_wdata_q;
    assign bus_if.vid_ack   = (state_q == S_VID_WAIT);
    assign bus_if.vid_rdata = bus_if.ram_rdata;
    assign bus_if.cpu_rdata = cpu_rdata_q;
    // Unselected CPU cycles must never be stalled.
    assign bus_if.cpu_ready = (state_q == S_CPU_HOLD) | ~bus_if.cpu_sel;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Scoreboard bench for mem_arbiter with a behavioural sync RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    localparam int XLEN = 8;
    localparam int AW   = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW), .VID_MAX_STREAK(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] mem [0:(1<<AW)-1];
    logic            pre_we   = 1'b0;
    logic [AW-1:0]   pre_addr = '0;
    logic [XLEN-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_en) bus.ram_rdata <= mem[bus.ram_addr];
    end

    logic [XLEN-1:0]      q_cpu [$];
    logic [XLEN-1:0]      q_vid [$];
    logic [AW+XLEN-1:0]   q_wr  [$];
    logic                 mon_rd_prev = 1'b0;
    logic                 mon_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        mon_rd = rst_n && bus.cpu_sel && bus.cpu_dbin && bus.cpu_write_n && bus.cpu_ready;
        if (bus.vid_ack) begin
            if (q_vid.size() == 0) unexpected("vid_ack");
            else chk("vid_rdata", 32'(bus.vid_rdata), 32'(q_vid.pop_front()));
        end
        if (bus.ram_we && !bus.ram_en) unexpected("ram_we_without_en");
        if (bus.ram_en && bus.ram_we) begin
            if (q_wr.size() == 0) unexpected("ram_write");
            else chk("ram_write", 32'({bus.ram_addr, bus.ram_wdata}), 32'(q_wr.pop_front()));
        end
        if (mon_rd && !mon_rd_prev) begin
            if (q_cpu.size() == 0) unexpected("cpu_read");
            else chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(q_cpu.pop_front()));
        end
        mon_rd_prev = mon_rd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        tick();
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Counts low-ready negedges before ready rises; -1 on timeout.
    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.cpu_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.cpu_ready) n = -1;
    endtask

    task automatic cpu_idle();
        bus.cpu_sel = 1'b0; bus.cpu_dbin = 1'b0; bus.cpu_write_n = 1'b1;
    endtask

    task automatic streak_round(input logic [AW-1:0] va, input logic [XLEN-1:0] vd,
                                input logic [15:0] ca, input logic [XLEN-1:0] cd,
                                input string name);
        int acks;
        int n;
        for (int i = 0; i < 4; i++) q_vid.push_back(vd);
        q_cpu.push_back(cd);
        tick();
        bus.vid_req = 1'b1; bus.vid_addr = va;
        bus.cpu_sel = 1'b1; bus.cpu_dbin = 1'b1; bus.cpu_addr = ca;
        acks = 0; n = 0;
        @(negedge clk);
        while (!bus.cpu_ready && n < 100) begin
            if (bus.vid_ack) acks++;
            n++;
            @(negedge clk);
        end
        chk({name, "_ready_seen"}, 32'(bus.cpu_ready), 32'd1);
        chk({name, "_acks"}, 32'(acks), 32'd4);
        tick();
        bus.cpu_dbin = 1'b0; bus.vid_req = 1'b0;
    endtask

    initial begin
        int  n;
        int  saw_en;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.vid_req = 1'b0; bus.vid_addr = '0;
        cpu_idle();

        // Reset state
        #1;
        chk("rst_ram_en",    32'(bus.ram_en),    32'd0);
        chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
        chk("rst_vid_ack",   32'(bus.vid_ack),   32'd0);
        chk("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: CPU read with truncated address
        preload(13'h0123, 8'h5A);
        q_cpu.push_back(8'h5A);
        tick();
        bus.cpu_sel = 1'b1; bus.cpu_dbin = 1'b1; bus.cpu_addr = 16'h2123;
        wait_ready(n);
        chk("t1_read_latency", 32'(n), 32'd3);
        tick();
        bus.cpu_dbin = 1'b0;
        @(negedge clk);
        chk("t1_hold_after_drop", 32'(bus.cpu_ready), 32'd1);
        @(negedge clk);
        chk("t1_idle_selected_ready", 32'(bus.cpu_ready), 32'd0);
        bus.cpu_sel = 1'b0;
        #1;
        chk("t1_idle_unselected_ready", 32'(bus.cpu_ready), 32'd1);

        // 2: CPU write
        q_wr.push_back({13'h0010, 8'hC3});
        tick();
        bus.cpu_sel = 1'b1; bus.cpu_write_n = 1'b0; bus.cpu_wdata = 8'hC3; bus.cpu_addr = 16'h0010;
        wait_ready(n);
        chk("t2_write_latency", 32'(n), 32'd2);
        tick();
        bus.cpu_write_n = 1'b1;
        tick();
        cpu_idle();
        tick();
        chk("t2_mem_written", 32'(mem[13'h0010]), 32'hC3);

        // 3: simultaneous video and CPU read, video first
        preload(13'h0200, 8'h11);
        preload(13'h0300, 8'h22);
        q_vid.push_back(8'h11);
        q_cpu.push_back(8'h22);
        tick();
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0200;
        bus.cpu_sel = 1'b1; bus.cpu_dbin = 1'b1; bus.cpu_addr = 16'h0300;
        n = 0;
        @(negedge clk);
        while (!bus.vid_ack && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("t3_vid_ack_cycle", 32'(n), 32'd2);
        chk("t3_cpu_waits_for_vid", 32'(bus.cpu_ready), 32'd0);
        @(posedge clk);
        #1 bus.vid_req = 1'b0;
        wait_ready(n);
        chk("t3_cpu_after_vid", 32'(n), 32'd3);
        tick();
        cpu_idle();
        tick();

        // 4: streak limit, then restart
        preload(13'h0400, 8'h33);
        preload(13'h0500, 8'h44);
        preload(13'h0600, 8'h55);
        preload(13'h0700, 8'h66);
        streak_round(13'h0400, 8'h33, 16'h0500, 8'h44, "t4a");
        streak_round(13'h0600, 8'h55, 16'h0700, 8'h66, "t4b");
        tick();
        cpu_idle();
        tick();

        // 5: unselected CPU strobe never stalls nor touches RAM
        bus.cpu_sel = 1'b0; bus.cpu_dbin = 1'b1; bus.cpu_addr = 16'h0123;
        #1;
        chk("t5_ready_same_cycle", 32'(bus.cpu_ready), 32'd1);
        saw_en = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ram_en) saw_en++;
        end
        chk("t5_no_ram_en", 32'(saw_en), 32'd0);
        cpu_idle();

        // 6: reset during CPU_WAIT
        preload(13'h0050, 8'h99);
        preload(13'h0001, 8'h77);
        tick();
        bus.cpu_sel = 1'b1; bus.cpu_dbin = 1'b1; bus.cpu_addr = 16'h0050;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ram_en",    32'(bus.ram_en),    32'd0);
        chk("t6_ram_we",    32'(bus.ram_we),    32'd0);
        chk("t6_vid_ack",   32'(bus.vid_ack),   32'd0);
        chk("t6_ram_addr",  32'(bus.ram_addr),  32'd0);
        chk("t6_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        chk("t6_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("t6_ready_sel", 32'(bus.cpu_ready), 32'd0);
        cpu_idle();
        #1;
        chk("t6_ready_unsel", 32'(bus.cpu_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        q_cpu.push_back(8'h77);
        tick();
        bus.cpu_sel = 1'b1; bus.cpu_dbin = 1'b1; bus.cpu_addr = 16'hE001;
        wait_ready(n);
        chk("t6_read_latency", 32'(n), 32'd3);
        tick();
        cpu_idle();
        repeat (3) tick();

        chk("q_cpu_drained", 32'(q_cpu.size()), 32'd0);
        chk("q_vid_drained", 32'(q_vid.size()), 32'd0);
        chk("q_wr_drained",  32'(q_wr.size()),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
